// File: rtl/usb_rst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_rst_pkg
// Brief    : Shared state encoding, register offsets and status bit layout
//            for the USB controller reset sequencer.
// Revision : 1.0
// ============================================================================
package usb_rst_pkg;

  localparam logic [1:0] ASSERT  = 2'd0;
  localparam logic [1:0] RECOVER = 2'd1;
  localparam logic [1:0] READY   = 2'd2;

  localparam logic [1:0] STATUS = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;

  localparam int STS_OTG_RST_N = 0;
  localparam int STS_USB_READY = 1;
  localparam int STS_STATE_LSB = 2;

  function automatic logic [31:0] status_word(input logic [1:0] st,
                                              input logic       rdy,
                                              input logic       otg);
    logic [31:0] w;
    w                       = '0;
    w[STS_STATE_LSB +: 2]   = st;
    w[STS_USB_READY]        = rdy;
    w[STS_OTG_RST_N]        = otg;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_rst_sequencer_if
// Brief    : Read-only Avalon-MM status slave bundle for the reset sequencer.
// Revision : 1.0
// ============================================================================
interface usb_rst_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/usb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rst_sequencer
// Brief    : Drives the USB controller reset pin from the PIO reset bit with
//            a minimum low width, post-release recovery and a status slave.
// Revision : 1.0
// ============================================================================
module usb_rst_sequencer
  import usb_rst_pkg::*;
#(
  parameter int ASSERT_CYCLES  = 2500,
  parameter int RECOVER_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  wire                        clk,
  input  wire                        reset_n,
  input  wire                        rst_ctl,
  output logic                       otg_rst_n,
  output logic                       usb_ready,
  usb_rst_sequencer_if.slave         avs
);

  localparam logic [CNT_W-1:0] c_assert_last  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_recover_last = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_otg_rst_n;
  logic             r_usb_ready;
  logic [7:0]       r_rst_count;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_otg_rst_n_nxt;
  logic             w_usb_ready_nxt;
  logic             w_count_inc;
  logic [31:0]      w_readdata;

  // Status reads are side-effect free, so the strobes carry no information.
  logic w_unused_strobes;
  assign w_unused_strobes = avs.chipselect ^ avs.read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ASSERT;
      r_cnt       <= '0;
      r_otg_rst_n <= 1'b0;
      r_usb_ready <= 1'b0;
      r_rst_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_otg_rst_n <= w_otg_rst_n_nxt;
      r_usb_ready <= w_usb_ready_nxt;
      if (w_count_inc && (r_rst_count != 8'hFF)) begin
        r_rst_count <= r_rst_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ASSERT: begin
        // Counter saturates so a long software hold just extends the low time.
        if (r_cnt == c_assert_last) begin
          if (rst_ctl) begin
            w_state_nxt = RECOVER;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      RECOVER: begin
        if (!rst_ctl) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_recover_last) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      READY: begin
        w_cnt_nxt = '0;
        if (!rst_ctl) begin
          w_state_nxt = ASSERT;
        end
      end
      default: begin
        w_state_nxt = ASSERT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as it.
  always_comb begin
    w_otg_rst_n_nxt = (w_state_nxt == RECOVER) || (w_state_nxt == READY);
    w_usb_ready_nxt = (w_state_nxt == READY);
    w_count_inc     = (r_state == RECOVER) && (w_state_nxt == READY);
  end

  always_comb begin
    w_readdata = 32'd0;
    case (avs.address)
      STATUS:  w_readdata = status_word(r_state, r_usb_ready, r_otg_rst_n);
      COUNT:   w_readdata = {24'd0, r_rst_count};
      default: w_readdata = 32'd0;
    endcase
  end

  assign avs.readdata = w_readdata;
  assign otg_rst_n    = r_otg_rst_n;
  assign usb_ready    = r_usb_ready;

endmodule
`default_nettype wire

// File: tb/tb_usb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rst_sequencer
// Brief    : Directed vector bench for usb_rst_sequencer (ASSERT=4, RECOVER=6).
// Revision : 1.0
// ============================================================================
module tb_usb_rst_sequencer;

  localparam int A_CYC = 4;
  localparam int R_CYC = 6;

  typedef struct {
    logic       rst_ctl;
    logic       exp_otg;
    logic       exp_rdy;
    logic [1:0] exp_st;
    logic [7:0] exp_cnt;
  } vec_t;

  logic clk;
  logic reset_n;
  logic rst_ctl;
  logic otg_rst_n;
  logic usb_ready;

  usb_rst_sequencer_if bus ();

  usb_rst_sequencer #(
    .ASSERT_CYCLES  (A_CYC),
    .RECOVER_CYCLES (R_CYC),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rst_ctl   (rst_ctl),
    .otg_rst_n (otg_rst_n),
    .usb_ready (usb_ready),
    .avs       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs [0:127];
  int   n_vec;
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic c, input logic o, input logic r,
                      input logic [1:0] s, input logic [7:0] n, input int times);
    for (int k = 0; k < times; k++) begin
      vecs[n_vec].rst_ctl = c;
      vecs[n_vec].exp_otg = o;
      vecs[n_vec].exp_rdy = r;
      vecs[n_vec].exp_st  = s;
      vecs[n_vec].exp_cnt = n;
      n_vec = n_vec + 1;
    end
  endtask

  task automatic read_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    #1;
    check(name, bus.readdata, exp);
  endtask

  // One record per clock edge: drive, clock, then check pins and both registers.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst_ctl = vecs[i].rst_ctl;
      @(posedge clk);
      #1;
      check($sformatf("otg_rst_n[v%0d]", i), {31'd0, otg_rst_n}, {31'd0, vecs[i].exp_otg});
      check($sformatf("usb_ready[v%0d]", i), {31'd0, usb_ready}, {31'd0, vecs[i].exp_rdy});
      read_chk($sformatf("status[v%0d]", i), 2'd0,
               {28'd0, vecs[i].exp_st, vecs[i].exp_rdy, vecs[i].exp_otg});
      read_chk($sformatf("rst_count[v%0d]", i), 2'd1, {24'd0, vecs[i].exp_cnt});
    end
  endtask

  int s3_end;
  int a_end;
  int b_end;

  initial begin
    n_vec    = 0;
    n_checks = 0;
    n_errors = 0;

    // power-up sequence
    push(1, 0, 0, 2'd0, 8'd0, 3);
    push(1, 1, 0, 2'd1, 8'd0, 6);
    push(1, 1, 1, 2'd2, 8'd1, 1);
    // single-cycle request stretched to 4 low cycles
    push(0, 0, 0, 2'd0, 8'd1, 1);
    push(1, 0, 0, 2'd0, 8'd1, 3);
    push(1, 1, 0, 2'd1, 8'd1, 6);
    push(1, 1, 1, 2'd2, 8'd2, 1);
    // 20-cycle request held for its full length
    push(0, 0, 0, 2'd0, 8'd2, 20);
    push(1, 1, 0, 2'd1, 8'd2, 6);
    push(1, 1, 1, 2'd2, 8'd3, 1);
    s3_end = n_vec;
    // abort on the third recovery cycle, then a full restart
    push(0, 0, 0, 2'd0, 8'd3, 1);
    push(1, 0, 0, 2'd0, 8'd3, 3);
    push(1, 1, 0, 2'd1, 8'd3, 3);
    push(0, 0, 0, 2'd0, 8'd3, 1);
    push(1, 0, 0, 2'd0, 8'd3, 3);
    push(1, 1, 0, 2'd1, 8'd3, 6);
    push(1, 1, 1, 2'd2, 8'd4, 1);
    a_end = n_vec;
    // sequence after an asynchronous reset mid-recovery
    push(1, 0, 0, 2'd0, 8'd0, 3);
    push(1, 1, 0, 2'd1, 8'd0, 6);
    push(1, 1, 1, 2'd2, 8'd1, 1);
    b_end = n_vec;

    reset_n        = 1'b1;
    rst_ctl        = 1'b1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset otg_rst_n", {31'd0, otg_rst_n}, 32'd0);
    check("reset usb_ready", {31'd0, usb_ready}, 32'd0);
    read_chk("reset status", 2'd0, 32'd0);
    read_chk("reset rst_count", 2'd1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_vecs(0, s3_end);

    read_chk("ready read addr0", 2'd0, 32'h0000000B);
    read_chk("ready read addr1", 2'd1, 32'h00000003);
    read_chk("ready read addr2", 2'd2, 32'h00000000);
    read_chk("ready read addr3", 2'd3, 32'h00000000);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    read_chk("read without strobes", 2'd0, 32'h0000000B);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;

    run_vecs(s3_end, a_end);

    // Enter recovery, then hit reset_n asynchronously between edges.
    rst_ctl = 1'b0;
    @(posedge clk);
    #1;
    read_chk("assert read addr0", 2'd0, 32'h00000000);
    rst_ctl = 1'b1;
    repeat (A_CYC + 1) @(posedge clk);
    #1;
    read_chk("pre-reset recover status", 2'd0, 32'h00000005);
    #2 reset_n = 1'b0;
    #1;
    check("async otg_rst_n", {31'd0, otg_rst_n}, 32'd0);
    check("async usb_ready", {31'd0, usb_ready}, 32'd0);
    read_chk("async rst_count", 2'd1, 32'd0);
    read_chk("async status", 2'd0, 32'd0);
    @(posedge clk);
    #1;
    check("held otg_rst_n", {31'd0, otg_rst_n}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_vecs(a_end, b_end);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rst_sequencer.md
# usb_rst_sequencer

Sequences the reset line of the on-board USB host controller from the software-written USB reset PIO bit. It sits directly downstream of the USB reset PIO: it consumes the PIO's single output bit and drives the controller's active-low reset pin. It enforces a minimum reset-low width and a post-release recovery time, and reports readiness. A read-only Avalon-MM status slave lets the Nios software poll readiness instead of busy-waiting with fixed delays.

## Interface
- ASSERT_CYCLES, 2500, minimum cycles reset pin held low (50 µs at 50 MHz); legal range 1..2^CNT_W-1
- RECOVER_CYCLES, 5000, cycles after release before ready is flagged (100 µs at 50 MHz); legal range 1..2^CNT_W-1
- CNT_W, 16, width of the shared cycle counter
- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- rst_ctl  in  1  PIO output bit; 0 = request controller reset, 1 = release; synchronous to clk
- otg_rst_n  out  1  registered reset pin to USB controller, active low
- usb_ready  out  1  registered; 1 = controller out of reset and recovered
- address  in  2  status slave word address
- chipselect  in  1  status slave select
- read  in  1  status slave read strobe
- readdata  out  32  status slave read data, combinational, zero wait states

## Operation
- States: ASSERT (2'd0), RECOVER (2'd1), READY (2'd2). Encoding 2'd3 is unused; if it is ever reached, next state is ASSERT with the counter cleared.
- Reset (reset_n low, asynchronous) forces:
  - state = ASSERT, cnt = 0
  - otg_rst_n = 0, usb_ready = 0, rst_count = 0
- ASSERT:
  - otg_rst_n = 0.
  - cnt increments each cycle and saturates at ASSERT_CYCLES-1.
  - Go to RECOVER with cnt cleared when cnt == ASSERT_CYCLES-1 and rst_ctl == 1 in the same cycle. Otherwise stay.
- RECOVER:
  - otg_rst_n = 1, cnt increments.
  - If rst_ctl == 0, go to ASSERT with cnt cleared. This abort has priority over completion.
  - Else if cnt == RECOVER_CYCLES-1, go to READY.
- READY:
  - otg_rst_n = 1, usb_ready = 1, cnt held at 0.
  - If rst_ctl == 0, go to ASSERT with cnt cleared.
- rst_count (8 bits) increments on each RECOVER→READY transition and saturates at 255.
- otg_rst_n and usb_ready are registered and decoded from the next state, so they change on the same edge as the state.
- Status map (address, readdata):
  - 0: {28'b0, state[1:0], usb_ready, otg_rst_n}
  - 1: {24'b0, rst_count}
  - 2, 3: 32'b0
- readdata does not depend on chipselect or read. Reads have no side effects. The slave has no write path.

## Timing
- rst_ctl sampled 0 at edge k while in READY or RECOVER: otg_rst_n is 0 after edge k.
- Low-width rule:
  - otg_rst_n stays low for max(ASSERT_CYCLES, number of consecutive sampled-0 cycles of rst_ctl) cycles.
  - A 1-cycle rst_ctl pulse is stretched to exactly ASSERT_CYCLES cycles.
- usb_ready rises exactly RECOVER_CYCLES cycles after otg_rst_n rises, provided no abort occurs.
- usb_ready falls on the same edge as otg_rst_n falls.
- After reset_n deasserts with rst_ctl = 1 throughout:
  - otg_rst_n rises at edge ASSERT_CYCLES.
  - usb_ready rises at edge ASSERT_CYCLES + RECOVER_CYCLES.
- Status read data is valid in the same cycle the address is presented.

## Structure
- Shared package usb_rst_pkg holds:
  - state encoding constants ASSERT / RECOVER / READY
  - register offsets STATUS = 0, COUNT = 1
  - status bit positions
- Single module, one counter of CNT_W bits shared by ASSERT and RECOVER. No sub-module is warranted.

## Test plan
All scenarios use ASSERT_CYCLES = 4 and RECOVER_CYCLES = 6.
- Release reset_n with rst_ctl = 1 -> otg_rst_n = 0 for edges 0..3, rises at edge 4; usb_ready rises at edge 10; rst_count = 1.
- In READY, rst_ctl = 0 for one cycle -> otg_rst_n low exactly 4 cycles, usb_ready low 10 cycles; rst_count = 2.
- In READY, rst_ctl = 0 for 20 cycles -> otg_rst_n low exactly 20 cycles, then usb_ready after 6 more cycles.
- rst_ctl = 0 on the 3rd RECOVER cycle -> otg_rst_n falls on the next edge, usb_ready never rises, rst_count unchanged, full 4-cycle assert restarts.
- reset_n pulsed low mid-RECOVER (asynchronous, between edges) -> otg_rst_n = 0, usb_ready = 0, rst_count = 0 immediately; the sequence restarts per scenario 1.
- Reads in READY after 3 completed sequences:
  - address 0 -> 0x0000000B
  - address 1 -> 0x00000003
  - address 2 -> 0x00000000
  - during ASSERT, address 0 -> 0x00000000
